rs_issue_release: RTL and testbench



---
 rtl/rs_issue_release.sv | 143 ++++++++++++++
 tb/tb_rs_issue_release.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rs_issue_release.sv
// Reservation-station release side: per-entry lifecycle tracking, round-robin issue slot with
// valid/ready handshake to the FU, and the free-entry vector returned to the allocator.
module rs_issue_release #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_ENTRIES-1:0] entry_allocate_i,
  input  logic                   alloc_ready_i,
  input  logic [NUM_ENTRIES-1:0] wakeup_i,
  input  logic                   flush_i,
  input  logic                   issue_ready_i,
  output logic                   issue_valid_o,
  output logic [NUM_ENTRIES-1:0] issue_entry_o,
  output logic [NUM_ENTRIES-1:0] entry_free_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    StFree,
    StWait,
    StReady,
    StIssued
  } ent_state_e;

  ent_state_e                 ent_state_q [NUM_ENTRIES];
  ent_state_e                 ent_state_d [NUM_ENTRIES];
  logic                       slot_valid_q, slot_valid_d;
  logic [NUM_ENTRIES-1:0]     slot_entry_q, slot_entry_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic                       handshake;
  logic                       slot_load;
  logic                       sel_found;
  logic [PTR_W-1:0]           sel_idx;
  logic [PTR_W-1:0]           scan_idx;

  assign handshake = slot_valid_q && issue_ready_i;
  assign slot_load = !slot_valid_q || handshake;

  // First READY entry at or above rr_ptr, wrapping; registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int unsigned o = 0; o < NUM_ENTRIES; o++) begin
      scan_idx = rr_ptr_q + PTR_W'(o);
      if (!sel_found && ent_state_q[scan_idx] == StReady) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_entry_d = slot_entry_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ent_state_d[i] = ent_state_q[i];
    end

    if (flush_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        ent_state_d[i] = StFree;
      end
      slot_valid_d = 1'b0;
      slot_entry_d = '0;
      rr_ptr_d     = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        unique case (ent_state_q[i])
          StFree: begin
            if (entry_allocate_i[i]) begin
              ent_state_d[i] = (alloc_ready_i || wakeup_i[i]) ? StReady : StWait;
            end
          end
          StWait: begin
            if (wakeup_i[i]) ent_state_d[i] = StReady;
          end
          StIssued: begin
            if (handshake && slot_entry_q[i]) ent_state_d[i] = StFree;
          end
          default: ;
        endcase
      end

      if (slot_load) begin
        if (sel_found) begin
          slot_valid_d          = 1'b1;
          slot_entry_d          = '0;
          slot_entry_d[sel_idx] = 1'b1;
          rr_ptr_d              = sel_idx + PTR_W'(1);
          ent_state_d[sel_idx]  = StIssued;
        end else begin
          slot_valid_d = 1'b0;
          slot_entry_d = '0;
        end
      end
    end

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_state_d[i] != StFree) count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        ent_state_q[i] <= StFree;
      end
      slot_valid_q <= 1'b0;
      slot_entry_q <= '0;
      rr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        ent_state_q[i] <= ent_state_d[i];
      end
      slot_valid_q <= slot_valid_d;
      slot_entry_q <= slot_entry_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    entry_free_o = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      entry_free_o[i] = (ent_state_q[i] == StFree);
    end
  end

  assign issue_valid_o = slot_valid_q;
  assign issue_entry_o = slot_entry_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_rs_issue_release.sv
// Directed bench for rs_issue_release with NUM_ENTRIES=4; expected values are hand-computed.
module tb_rs_issue_release;

  localparam int unsigned N = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [N-1:0]  entry_allocate_i = '0;
  logic          alloc_ready_i = 1'b0;
  logic [N-1:0]  wakeup_i = '0;
  logic          flush_i = 1'b0;
  logic          issue_ready_i = 1'b0;
  logic          issue_valid_o;
  logic [N-1:0]  issue_entry_o;
  logic [N-1:0]  entry_free_o;
  logic [CW-1:0] count_o;

  int tests_run = 0;
  int tests_failed = 0;

  rs_issue_release #(.NUM_ENTRIES(N)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .entry_allocate_i (entry_allocate_i),
    .alloc_ready_i    (alloc_ready_i),
    .wakeup_i         (wakeup_i),
    .flush_i          (flush_i),
    .issue_ready_i    (issue_ready_i),
    .issue_valid_o    (issue_valid_o),
    .issue_entry_o    (issue_entry_o),
    .entry_free_o     (entry_free_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [N-1:0] e,
                           input logic [N-1:0] f, input logic [CW-1:0] c);
    check({tag, ".valid"}, 32'(issue_valid_o), 32'(v));
    check({tag, ".entry"}, 32'(issue_entry_o), 32'(e));
    check({tag, ".free"}, 32'(entry_free_o), 32'(f));
    check({tag, ".count"}, 32'(count_o), 32'(c));
  endtask

  initial begin
    logic [N-1:0] exp_order [4];

    // Reset then idle
    step(); step();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("idle", 1'b0, 4'b0000, 4'b1111, 3'd0);
    end

    // Allocate-ready entry 0, minimum latency
    entry_allocate_i = 4'b0001; alloc_ready_i = 1'b1; issue_ready_i = 1'b1;
    step();
    entry_allocate_i = '0; alloc_ready_i = 1'b0;
    check_all("lat.t1", 1'b0, 4'b0000, 4'b1110, 3'd1);
    step();
    check_all("lat.t2", 1'b1, 4'b0001, 4'b1110, 3'd1);
    step();
    check_all("lat.t3", 1'b0, 4'b0000, 4'b1111, 3'd0);

    // Three WAIT entries woken together
    flush_i = 1'b1; step(); flush_i = 1'b0;
    entry_allocate_i = 4'b0001; step();
    entry_allocate_i = 4'b0010; step();
    entry_allocate_i = 4'b0100; step();
    entry_allocate_i = '0;
    check_all("wait.alloc", 1'b0, 4'b0000, 4'b1000, 3'd3);
    wakeup_i = 4'b0111; step(); wakeup_i = '0;
    check_all("wait.woke", 1'b0, 4'b0000, 4'b1000, 3'd3);
    step(); check_all("wait.i0", 1'b1, 4'b0001, 4'b1000, 3'd3);
    step(); check_all("wait.i1", 1'b1, 4'b0010, 4'b1001, 3'd2);
    step(); check_all("wait.i2", 1'b1, 4'b0100, 4'b1011, 3'd1);
    step(); check_all("wait.done", 1'b0, 4'b0000, 4'b1111, 3'd0);

    // Round robin from rr_ptr=2 (set by issuing entry 1 after a flush)
    flush_i = 1'b1; step(); flush_i = 1'b0;
    entry_allocate_i = 4'b0010; alloc_ready_i = 1'b1; step();
    entry_allocate_i = '0; alloc_ready_i = 1'b0;
    step(); check("rr.pre", 32'(issue_entry_o), 32'b0010);
    step();
    for (int i = 0; i < 4; i++) begin
      entry_allocate_i = '0;
      entry_allocate_i[i] = 1'b1;
      step();
    end
    entry_allocate_i = '0;
    wakeup_i = 4'b1111; step(); wakeup_i = '0;
    check_all("rr.ready", 1'b0, 4'b0000, 4'b0000, 3'd4);
    exp_order[0] = 4'b0100; exp_order[1] = 4'b1000;
    exp_order[2] = 4'b0001; exp_order[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr.order%0d", i), 32'(issue_entry_o), 32'(exp_order[i]));
      check($sformatf("rr.cnt%0d", i), 32'(count_o), 32'(4 - i));
    end
    // Entry 0 reallocated READY while entry 1 handshakes: count net unchanged
    entry_allocate_i = 4'b0001; alloc_ready_i = 1'b1; step();
    entry_allocate_i = '0; alloc_ready_i = 1'b0;
    check_all("rr.realloc", 1'b0, 4'b0000, 4'b1110, 3'd1);
    step(); check_all("rr.reissue", 1'b1, 4'b0001, 4'b1110, 3'd1);
    step(); check_all("rr.done", 1'b0, 4'b0000, 4'b1111, 3'd0);

    // Backpressure: entry 2 held while entry 3 becomes READY
    flush_i = 1'b1; step(); flush_i = 1'b0;
    issue_ready_i = 1'b0;
    entry_allocate_i = 4'b0100; alloc_ready_i = 1'b1; step();
    entry_allocate_i = '0; alloc_ready_i = 1'b0;
    step(); check("bp.load", 32'(issue_entry_o), 32'b0100);
    entry_allocate_i = 4'b1000; step(); entry_allocate_i = '0;
    check("bp.hold0", 32'(issue_entry_o), 32'b0100);
    wakeup_i = 4'b1000; step(); wakeup_i = '0;
    check("bp.hold1", 32'(issue_entry_o), 32'b0100);
    for (int i = 2; i < 5; i++) begin
      step();
      check_all($sformatf("bp.hold%0d", i), 1'b1, 4'b0100, 4'b0011, 3'd2);
    end
    issue_ready_i = 1'b1; step();
    check_all("bp.next", 1'b1, 4'b1000, 4'b0111, 3'd1);
    step(); check_all("bp.done", 1'b0, 4'b0000, 4'b1111, 3'd0);

    // Flush with busy entries and same-cycle allocate
    issue_ready_i = 1'b0;
    entry_allocate_i = 4'b0001; alloc_ready_i = 1'b1; step();
    alloc_ready_i = 1'b0;
    entry_allocate_i = 4'b0010; step();
    entry_allocate_i = 4'b0100; step();
    check_all("fl.busy", 1'b1, 4'b0001, 4'b1000, 3'd3);
    entry_allocate_i = 4'b0010; alloc_ready_i = 1'b1; step();
    check_all("fl.dupalloc", 1'b1, 4'b0001, 4'b1000, 3'd3);
    entry_allocate_i = 4'b1000; flush_i = 1'b1; issue_ready_i = 1'b1; step();
    entry_allocate_i = '0; flush_i = 1'b0; alloc_ready_i = 1'b0;
    check_all("fl.after", 1'b0, 4'b0000, 4'b1111, 3'd0);
    step(); check_all("fl.idle", 1'b0, 4'b0000, 4'b1111, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
